// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch sequencer: credit-limited imem requests, response queue, redirect flush
// Optional perf counters when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl #(
  parameter int                       CPU_ADDR_BITS = 32,
  parameter int                       CPU_INST_BITS = 32,
  parameter int                       FETCH_WIDTH   = 2,
  parameter int                       MAX_INFLIGHT  = 4,
  parameter logic [CPU_ADDR_BITS-1:0] RESET_PC      = '0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 redirect_val,
  input  logic [CPU_ADDR_BITS-1:0]             redirect_pc,
  output logic                                 imem_req_val,
  output logic [CPU_ADDR_BITS-1:0]             imem_req_addr,
  input  logic                                 imem_req_rdy,
  input  logic                                 imem_rsp_val,
  input  logic [FETCH_WIDTH*CPU_INST_BITS-1:0] imem_rsp_packet,
  output logic                                 buf_val,
  output logic [CPU_ADDR_BITS-1:0]             buf_pc,
  output logic [FETCH_WIDTH*CPU_INST_BITS-1:0] buf_packet,
  input  logic                                 buf_rdy
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]                          perf_stall_cycles,
  output logic [31:0]                          perf_discarded
`endif
);
  localparam int PW = FETCH_WIDTH * CPU_INST_BITS;
  localparam int AW = $clog2(MAX_INFLIGHT);
  localparam int CW = AW + 1;
  localparam logic [CPU_ADDR_BITS-1:0] PC_STEP = CPU_ADDR_BITS'(FETCH_WIDTH * 4);
  localparam logic [CW:0] CREDITS = (CW + 1)'(MAX_INFLIGHT);

  typedef enum logic {BOOT, RUN} state_t;
  state_t state, state_next;

  logic [CPU_ADDR_BITS-1:0] fetch_pc;
  logic [CPU_ADDR_BITS-1:0] pc_fifo  [MAX_INFLIGHT];
  logic [CPU_ADDR_BITS-1:0] q_pc     [MAX_INFLIGHT];
  logic [PW-1:0]            q_packet [MAX_INFLIGHT];
  logic [CW-1:0]            pf_wr, pf_rd, q_wr, q_rd;
  logic [CW-1:0]            outstanding, outstanding_next, stale_cnt, q_count;
  logic                     req_hs, rsp_keep, rsp_drop, buf_pop;

  assign q_count       = q_wr - q_rd;
  assign buf_val       = (q_count != '0);
  assign buf_pc        = q_pc[q_rd[AW-1:0]];
  assign buf_packet    = q_packet[q_rd[AW-1:0]];
  assign imem_req_addr = fetch_pc;

  // Queued responses hold credits too, so a full queue can always absorb every outstanding reply.
  always_comb begin
    state_next   = state;
    imem_req_val = 1'b0;
    case (state)
      BOOT: state_next = RUN;
      RUN:  imem_req_val = ~redirect_val & (({1'b0, outstanding} + {1'b0, q_count}) < CREDITS);
    endcase
    if (redirect_val) state_next = RUN;
    req_hs           = imem_req_val & imem_req_rdy;
    rsp_drop         = imem_rsp_val & (redirect_val | (stale_cnt != '0));
    rsp_keep         = imem_rsp_val & ~rsp_drop;
    buf_pop          = buf_val & buf_rdy & ~redirect_val;
    outstanding_next = outstanding + CW'(req_hs) - CW'(imem_rsp_val);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      pf_wr       <= '0;
      pf_rd       <= '0;
      q_wr        <= '0;
      q_rd        <= '0;
      outstanding <= '0;
      stale_cnt   <= '0;
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        pc_fifo[i]  <= '0;
        q_pc[i]     <= '0;
        q_packet[i] <= '0;
      end
    end else begin
      state       <= state_next;
      outstanding <= outstanding_next;
      if (redirect_val) begin
        // Everything still in flight after this edge belongs to the old stream.
        fetch_pc  <= redirect_pc;
        pf_wr     <= '0;
        pf_rd     <= '0;
        q_wr      <= '0;
        q_rd      <= '0;
        stale_cnt <= outstanding_next;
      end else begin
        if (req_hs) begin
          pc_fifo[pf_wr[AW-1:0]] <= fetch_pc;
          pf_wr                  <= pf_wr + 1'b1;
          fetch_pc               <= fetch_pc + PC_STEP;
        end
        if (rsp_drop) stale_cnt <= stale_cnt - 1'b1;
        if (rsp_keep) begin
          q_pc[q_wr[AW-1:0]]     <= pc_fifo[pf_rd[AW-1:0]];
          q_packet[q_wr[AW-1:0]] <= imem_rsp_packet;
          q_wr                   <= q_wr + 1'b1;
          pf_rd                  <= pf_rd + 1'b1;
        end
        if (buf_pop) q_rd <= q_rd + 1'b1;
      end
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_discarded    <= '0;
    end else begin
      if (state == RUN && !redirect_val && !req_hs && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (rsp_drop && perf_discarded != '1)
        perf_discarded <= perf_discarded + 32'd1;
    end
  end
`endif

endmodule
